serpent_encrypt_arbiter: RTL and testbench

Shares one serpent_encrypt core among NUM_REQ block-encryption requesters using round-robin arbitration.
- Grants a request only while the key schedule reports subkeys valid.
- Latches the winner's plaintext, starts the core, waits for completion and returns the ciphertext to the winner.
- A watchdog aborts a core run that never completes and flags an error.

---
 rtl/serpent_encrypt_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_serpent_encrypt_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_encrypt_arbiter.sv
// -----------------------------------------------------------------------------
// serpent_encrypt_arbiter
//   Shares one serpent_encrypt core among NUM_REQ block-encryption requesters
//   using round-robin arbitration. A request is granted only while the key
//   schedule reports valid subkeys. The winner's plaintext is latched and
//   presented to the core, the core is started, and its ciphertext is returned
//   to the winner. A watchdog aborts a core run that never completes and
//   returns an error response instead.
//
// Handshake semantics (all outputs registered):
//   requester : i_req[k] is a level held until o_req_ack[k] pulses for one
//               cycle; i_req_data slice k is sampled only at the grant edge.
//               o_rsp_valid[k] pulses for one cycle with o_rsp_data/o_rsp_err,
//               which then hold until the next response.
//   core      : o_core_en pulses one cycle (the ack cycle); o_core_data stays
//               stable until the core answers with a one-cycle i_core_done
//               carrying i_core_data. A done outside WAIT is ignored.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req, i_req_data     per-requester request level and 128-bit plaintext
//   o_req_ack             one-hot accept pulse
//   o_rsp_valid           one-hot response pulse
//   o_rsp_data, o_rsp_err ciphertext and timeout flag of the last response
//   i_subkey_valid        key schedule complete; gates new grants only
//   o_core_en, o_core_data  core start pulse and plaintext
//   i_core_done, i_core_data  core completion pulse and ciphertext
//   o_busy                high while in RUN/WAIT
//   o_grant_id            index of the current or last granted requester
// -----------------------------------------------------------------------------
module serpent_encrypt_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [128*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [127:0]           o_rsp_data,
  output logic                   o_rsp_err,
  input  logic                   i_subkey_valid,
  output logic                   o_core_en,
  output logic [127:0]           o_core_data,
  input  logic                   i_core_done,
  input  logic [127:0]           i_core_data,
  output logic                   o_busy,
  output logic [2:0]             o_grant_id
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t         state_q, state_n;
  logic [2:0]     rr_ptr_q;
  logic [2:0]     rr_ptr_n;
  logic [CW-1:0]  wd_cnt_q;

  logic               found;
  logic [2:0]         win;
  logic [127:0]       win_data;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant;
  logic               timeout_hit;

  // Round-robin search: distance i from the pointer, first set request wins.
  // The pointer is always < NUM_REQ, so the wrapped index is ptr+i or
  // ptr+i-NUM_REQ; comparing against both avoids a modulo.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    win_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && i_req[j] &&
            ((int'(rr_ptr_q) + i == j) || (int'(rr_ptr_q) + i == j + NUM_REQ))) begin
          found     = 1'b1;
          win       = 3'(j);
          win_data  = i_req_data[128*j +: 128];
          win_oh    = '0;
          win_oh[j] = 1'b1;
        end
      end
    end
  end

  // With NUM_REQ=1 the winner is always 0, so the pointer stays 0.
  assign rr_ptr_n    = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
  assign grant       = (state_q == S_IDLE) && i_subkey_valid && found;
  assign timeout_hit = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // The response goes back to the requester recorded in o_grant_id.
  always_comb begin
    grant_oh = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant_oh[j] = (o_grant_id == 3'(j));
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic. Done has priority over the watchdog in the same cycle.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (grant) state_n = S_RUN;
      S_RUN:  state_n = S_WAIT;
      S_WAIT: begin
        if (i_core_done)      state_n = S_IDLE;
        else if (timeout_hit) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered datapath and outputs. Pulses default low every cycle so they
  // can never stretch beyond one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q    <= '0;
      wd_cnt_q    <= '0;
      o_req_ack   <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_core_en   <= 1'b0;
      o_core_data <= '0;
      o_busy      <= 1'b0;
      o_grant_id  <= '0;
    end else begin
      o_req_ack   <= '0;
      o_rsp_valid <= '0;
      o_core_en   <= 1'b0;
      o_busy      <= (state_n != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            o_core_data <= win_data;
            o_grant_id  <= win;
            rr_ptr_q    <= rr_ptr_n;
            o_req_ack   <= win_oh;
            o_core_en   <= 1'b1;
          end
        end
        S_RUN: begin
          // Counter reads 0 in the first WAIT cycle.
          wd_cnt_q <= '0;
        end
        S_WAIT: begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
          if (i_core_done) begin
            o_rsp_valid <= grant_oh;
            o_rsp_data  <= i_core_data;
            o_rsp_err   <= 1'b0;
          end else if (timeout_hit) begin
            o_rsp_valid <= grant_oh;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serpent_encrypt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serpent_encrypt_arbiter
//   Directed bench for serpent_encrypt_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=64).
//   Inputs are driven and outputs sampled 1 ns after each rising edge. A small
//   behavioural core answers o_core_en with i_core_done after core_delay
//   cycles (core_delay <= 0 means it never answers).
// -----------------------------------------------------------------------------
module tb_serpent_encrypt_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TO      = 64;

  logic         clk;
  logic         i_rst;
  logic [1:0]   i_req;
  logic [255:0] i_req_data;
  logic [1:0]   o_req_ack;
  logic [1:0]   o_rsp_valid;
  logic [127:0] o_rsp_data;
  logic         o_rsp_err;
  logic         i_subkey_valid;
  logic         o_core_en;
  logic [127:0] o_core_data;
  logic         i_core_done;
  logic [127:0] i_core_data;
  logic         o_busy;
  logic [2:0]   o_grant_id;

  int n_total;
  int n_pass;

  // core model state
  int           core_delay;
  int           cnt_down;
  logic         core_done;
  logic [127:0] core_resp;
  logic [127:0] core_out;
  logic         spur_done;
  logic [127:0] spur_data;

  assign i_core_done = core_done | spur_done;
  assign i_core_data = spur_done ? spur_data : core_out;

  serpent_encrypt_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_req          (i_req),
    .i_req_data     (i_req_data),
    .o_req_ack      (o_req_ack),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_data     (o_rsp_data),
    .o_rsp_err      (o_rsp_err),
    .i_subkey_valid (i_subkey_valid),
    .o_core_en      (o_core_en),
    .o_core_data    (o_core_data),
    .i_core_done    (i_core_done),
    .i_core_data    (i_core_data),
    .o_busy         (o_busy),
    .o_grant_id     (o_grant_id)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural core
  initial begin
    cnt_down  = 0;
    core_done = 1'b0;
    core_out  = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (i_rst) begin
        cnt_down = 0;
      end else begin
        if (cnt_down > 0) begin
          cnt_down--;
          if (cnt_down == 0) begin
            core_done = 1'b1;
            core_out  = core_resp;
          end
        end
        if (o_core_en && core_delay > 0) cnt_down = core_delay;
      end
    end
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (o_rsp_valid == 2'b00 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    n_total++;
    if (o_req_ack !== 2'b00 || o_rsp_valid !== 2'b00 || o_core_en !== 1'b0 || o_busy !== 1'b0) begin
      $display("FAIL reset_ctrl: ack=%b rsp_valid=%b core_en=%b busy=%b, want all 0",
               o_req_ack, o_rsp_valid, o_core_en, o_busy);
    end else n_pass++;
    n_total++;
    if (o_core_data !== '0 || o_rsp_data !== '0 || o_rsp_err !== 1'b0 || o_grant_id !== 3'd0) begin
      $display("FAIL reset_data: core_data=%h rsp_data=%h err=%b gid=%0d, want all 0",
               o_core_data, o_rsp_data, o_rsp_err, o_grant_id);
    end else n_pass++;
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    core_delay = 33;
    core_resp  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    i_req_data[127:0] = 128'h1;
    i_req = 2'b01;
    tick();
    n_total++;
    if (o_req_ack !== 2'b01 || o_core_en !== 1'b1 || o_busy !== 1'b1) begin
      $display("FAIL single_ack: ack=%b core_en=%b busy=%b, want 01 1 1", o_req_ack, o_core_en, o_busy);
    end else n_pass++;
    n_total++;
    if (o_core_data !== 128'h1 || o_grant_id !== 3'd0) begin
      $display("FAIL single_latch: core_data=%h gid=%0d, want 1 0", o_core_data, o_grant_id);
    end else n_pass++;
    i_req = 2'b00;
    i_req_data[127:0] = 128'hFFFF;
    wait_rsp(n);
    n_total++;
    if (n !== 34) begin
      $display("FAIL single_latency: rsp after %0d cycles, want 34", n);
    end else n_pass++;
    n_total++;
    if (o_rsp_valid !== 2'b01 || o_rsp_data !== 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF || o_rsp_err !== 1'b0) begin
      $display("FAIL single_rsp: valid=%b data=%h err=%b, want 01 deadbeef.. 0", o_rsp_valid, o_rsp_data, o_rsp_err);
    end else n_pass++;
    tick();
    n_total++;
    if (o_rsp_valid !== 2'b00 || o_rsp_data !== 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF) begin
      $display("FAIL single_hold: valid=%b data=%h, want 00 deadbeef..", o_rsp_valid, o_rsp_data);
    end else n_pass++;
  endtask

  // pointer is 1 on entry
  task automatic test_subkey_gating();
    int n;
    int bad;
    bad = 0;
    core_delay = 5;
    core_resp  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    i_subkey_valid = 1'b0;
    i_req_data[255:128] = 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A;
    i_req = 2'b10;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_req_ack !== 2'b00 || o_core_en !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) begin
      $display("FAIL gating_no_ack: %0d cycles with ack/core_en while subkeys invalid, want 0", bad);
    end else n_pass++;
    i_subkey_valid = 1'b1;
    tick();
    n_total++;
    if (o_req_ack !== 2'b10 || o_core_en !== 1'b1 || o_grant_id !== 3'd1) begin
      $display("FAIL gating_ack: ack=%b core_en=%b gid=%0d, want 10 1 1", o_req_ack, o_core_en, o_grant_id);
    end else n_pass++;
    n_total++;
    if (o_core_data !== 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A) begin
      $display("FAIL gating_data: core_data=%h, want a5a5..5a5a", o_core_data);
    end else n_pass++;
    i_req = 2'b00;
    wait_rsp(n);
    n_total++;
    if (n !== 6 || o_rsp_valid !== 2'b10 || o_rsp_data !== 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677) begin
      $display("FAIL gating_rsp: n=%0d valid=%b data=%h, want 6 10 0123..6677", n, o_rsp_valid, o_rsp_data);
    end else n_pass++;
  endtask

  // pointer is 0 on entry
  task automatic test_contention();
    logic [1:0] exp_ack [4];
    int         k;
    int         cyc;
    int         n;
    exp_ack[0] = 2'b01;
    exp_ack[1] = 2'b10;
    exp_ack[2] = 2'b01;
    exp_ack[3] = 2'b10;
    core_delay = 3;
    core_resp  = 128'hC0FFEE;
    i_req = 2'b11;
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 300) begin
      tick();
      cyc++;
      if (o_req_ack != 2'b00) begin
        n_total++;
        if (o_req_ack !== exp_ack[k] || o_core_en !== 1'b1 || o_grant_id !== 3'(k % 2)) begin
          $display("FAIL contention_grant%0d: ack=%b core_en=%b gid=%0d, want %b 1 %0d",
                   k, o_req_ack, o_core_en, o_grant_id, exp_ack[k], k % 2);
        end else n_pass++;
        k++;
      end
    end
    i_req = 2'b00;
    n_total++;
    if (k !== 4) begin
      $display("FAIL contention_count: %0d grants seen, want 4", k);
    end else n_pass++;
    wait_rsp(n);
    n_total++;
    if (o_rsp_valid !== 2'b10 || o_rsp_data !== 128'hC0FFEE) begin
      $display("FAIL contention_rsp: valid=%b data=%h, want 10 c0ffee", o_rsp_valid, o_rsp_data);
    end else n_pass++;
  endtask

  // pointer is 0 on entry
  task automatic test_back_to_back();
    int n;
    core_delay = 3;
    core_resp  = 128'hB2B;
    i_req = 2'b01;
    tick();
    n_total++;
    if (o_req_ack !== 2'b01) begin
      $display("FAIL b2b_ack0: ack=%b, want 01", o_req_ack);
    end else n_pass++;
    i_req = 2'b10;
    wait_rsp(n);
    n_total++;
    if (o_rsp_valid !== 2'b01 || o_req_ack !== 2'b00) begin
      $display("FAIL b2b_rsp0: valid=%b ack=%b, want 01 00", o_rsp_valid, o_req_ack);
    end else n_pass++;
    tick();
    n_total++;
    if (o_req_ack !== 2'b10 || o_core_en !== 1'b1 || o_grant_id !== 3'd1) begin
      $display("FAIL b2b_ack1: ack=%b core_en=%b gid=%0d, want 10 1 1", o_req_ack, o_core_en, o_grant_id);
    end else n_pass++;
    i_req = 2'b00;
    wait_rsp(n);
    n_total++;
    if (o_rsp_valid !== 2'b10) begin
      $display("FAIL b2b_rsp1: valid=%b, want 10", o_rsp_valid);
    end else n_pass++;
  endtask

  // pointer is 0 on entry; run grants 0 so the pointer would be 1 without reset
  task automatic test_reset_mid_wait();
    int n;
    int bad;
    core_delay = 0;
    i_req = 2'b01;
    tick();
    i_req = 2'b00;
    for (int c = 0; c < 10; c++) tick();
    i_rst = 1'b1;
    #1;
    n_total++;
    if (o_busy !== 1'b0 || o_core_data !== '0 || o_rsp_data !== '0 || o_grant_id !== 3'd0 ||
        o_rsp_valid !== 2'b00 || o_req_ack !== 2'b00 || o_core_en !== 1'b0 || o_rsp_err !== 1'b0) begin
      $display("FAIL rst_mid_outputs: busy=%b core_data=%h rsp_data=%h gid=%0d, want all 0",
               o_busy, o_core_data, o_rsp_data, o_grant_id);
    end else n_pass++;
    tick();
    i_rst = 1'b0;
    bad = 0;
    for (int c = 0; c < TO + 5; c++) begin
      tick();
      if (o_rsp_valid !== 2'b00 || o_busy !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) begin
      $display("FAIL rst_mid_no_rsp: %0d cycles with response/busy after reset, want 0", bad);
    end else n_pass++;
    core_delay = 3;
    core_resp  = 128'h5EED;
    i_req = 2'b11;
    tick();
    n_total++;
    if (o_req_ack !== 2'b01 || o_grant_id !== 3'd0) begin
      $display("FAIL rst_mid_ptr: ack=%b gid=%0d, want 01 0", o_req_ack, o_grant_id);
    end else n_pass++;
    i_req = 2'b00;
    wait_rsp(n);
    n_total++;
    if (o_rsp_valid !== 2'b01 || o_rsp_data !== 128'h5EED || o_rsp_err !== 1'b0) begin
      $display("FAIL rst_mid_rsp: valid=%b data=%h err=%b, want 01 5eed 0", o_rsp_valid, o_rsp_data, o_rsp_err);
    end else n_pass++;
  endtask

  // pointer is 1 on entry
  task automatic test_timeout();
    int n;
    core_delay = 0;
    i_req = 2'b10;
    tick();
    n_total++;
    if (o_req_ack !== 2'b10 || o_core_en !== 1'b1) begin
      $display("FAIL timeout_ack: ack=%b core_en=%b, want 10 1", o_req_ack, o_core_en);
    end else n_pass++;
    i_req = 2'b00;
    wait_rsp(n);
    n_total++;
    if (n !== TO + 1) begin
      $display("FAIL timeout_latency: rsp after %0d cycles, want %0d", n, TO + 1);
    end else n_pass++;
    n_total++;
    if (o_rsp_valid !== 2'b10 || o_rsp_data !== '0 || o_rsp_err !== 1'b1) begin
      $display("FAIL timeout_rsp: valid=%b data=%h err=%b, want 10 0 1", o_rsp_valid, o_rsp_data, o_rsp_err);
    end else n_pass++;
    spur_data = 128'h1234_5678;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    n_total++;
    if (o_rsp_valid !== 2'b00 || o_rsp_data !== '0 || o_rsp_err !== 1'b1 || o_busy !== 1'b0) begin
      $display("FAIL timeout_spurious: valid=%b data=%h err=%b busy=%b, want 00 0 1 0",
               o_rsp_valid, o_rsp_data, o_rsp_err, o_busy);
    end else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_total        = 0;
    n_pass         = 0;
    i_rst          = 1'b1;
    i_req          = 2'b00;
    i_req_data     = '0;
    i_subkey_valid = 1'b1;
    core_delay     = 0;
    core_resp      = '0;
    spur_done      = 1'b0;
    spur_data      = '0;

    test_reset();
    test_single();
    test_subkey_gating();
    test_contention();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
